// File: rtl/uart_rx_16x_if.sv
// Receiver-side bundle: oversample strobe, serial line, consumer handshake and status.
interface uart_rx_16x_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rxclk_en;
  logic                 rx;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;

  modport slave (
    input  rxclk_en,
    input  rx,
    input  rdy_clr,
    output data,
    output rdy,
    output frame_err,
    output overrun
  );

  modport master (
    output rxclk_en,
    output rx,
    output rdy_clr,
    input  data,
    input  rdy,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver on a 16x oversample strobe: start-bit qualification, mid-bit
// sampling, ready/clear handshake, framing-error and overrun flags.
module uart_rx_16x #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic          clk_12m,
  input  logic          rst,
  uart_rx_16x_if.slave  bus
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_rx_meta;
  logic                 r_rx_s;

  logic                 w_bit_mid;

  assign w_bit_mid = (r_cnt == CNT_LAST);

  // Two-flop synchronizer; idle-high reset value keeps a reset from looking like a start edge.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM and handshake; a completion on the same edge as rdy_clr overrides the clear.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (bus.rdy_clr) begin
        r_rdy     <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (bus.rxclk_en) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end

          S_START: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_HALF) begin
              if (r_rx_s) begin
                r_state <= S_IDLE;
              end else begin
                r_state   <= S_DATA;
                r_cnt     <= '0;
                r_bit_idx <= '0;
              end
            end
          end

          S_DATA: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_bit_mid) begin
              r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
              r_cnt   <= '0;
              if (r_bit_idx == IDX_LAST) begin
                r_state <= S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
              end
            end
          end

          S_STOP: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_bit_mid) begin
              r_data      <= r_shreg;
              r_rdy       <= 1'b1;
              r_frame_err <= ~r_rx_s;
              r_overrun   <= bus.rdy_clr ? 1'b0 : (r_overrun | r_rdy);
              r_cnt       <= '0;
              r_state     <= r_rx_s ? S_IDLE : S_BREAK;
            end
          end

          S_BREAK: begin
            // Held-low line must return high before another frame can start.
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
